// File: rtl/mod_pwm_pkg.sv
// Shared constants for the two-channel servo PWM pair: default timing,
// servo duty limits and channel indices.
package mod_pwm_pkg;

  // Default timing: 50 MHz clk / 50 gives a 1 us tick, 20000 ticks is a 20 ms frame.
  localparam int PRESCALE_DEFAULT = 50;
  localparam int PERIOD_DEFAULT   = 20000;

  // Legal servo pulse window in ticks (1.0 ms .. 2.0 ms at the default tick).
  localparam int SERVO_MIN_DUTY = 1000;
  localparam int SERVO_MAX_DUTY = 2000;

  // Channel indices; they also match the demux select encoding.
  localparam int CH1 = 0;
  localparam int CH2 = 1;

  // Width of duty values and of the shared counters.
  localparam int DUTY_W = 16;

endpackage : mod_pwm_pkg

// File: rtl/mod_pwm_channel.sv
// One PWM channel: a shadow duty register loaded on a strobe, an active
// duty register refreshed only at a period boundary (or at once while the
// counters are disabled), and a registered compare against the shared
// period counter.
// Optional feature: define PWM_CLAMP_EN to saturate captured duties to
// [SERVO_MIN_DUTY, SERVO_MAX_DUTY].
module mod_pwm_channel
  import mod_pwm_pkg::*;
#(
  parameter int DATA_W = DUTY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              boundary,
  input  logic              cap,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] period_nxt,
  output logic              pwm,
  output logic              pending,
  output logic [DATA_W-1:0] active
);

  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] shadow_nxt;
  logic [DATA_W-1:0] active_nxt;
  logic              pending_nxt;
  logic              xfer;
  logic              pwm_p1;

  // Saturate a captured duty to the servo window when clamping is built in.
  function automatic logic [DATA_W-1:0] sat_duty(input logic [DATA_W-1:0] d);
`ifdef PWM_CLAMP_EN
    if (d < DATA_W'(SERVO_MIN_DUTY)) begin
      return DATA_W'(SERVO_MIN_DUTY);
    end else if (d > DATA_W'(SERVO_MAX_DUTY)) begin
      return DATA_W'(SERVO_MAX_DUTY);
    end else begin
      return d;
    end
`else
    return d;
`endif
  endfunction

  // Next-state for shadow/active/pending. A transfer moves the value that
  // was in the shadow before this cycle, so a load landing on the boundary
  // is kept for the following period and leaves pending set.
  always_comb begin
    xfer        = pending && (boundary || !enable);
    shadow_nxt  = shadow;
    active_nxt  = active;
    pending_nxt = pending;
    if (xfer) begin
      active_nxt  = shadow;
      pending_nxt = 1'b0;
    end
    if (cap) begin
      shadow_nxt  = sat_duty(din);
      pending_nxt = 1'b1;
    end
  end

  // Register duty state; reset returns the channel to an idle 0 duty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      shadow  <= shadow_nxt;
      active  <= active_nxt;
      pending <= pending_nxt;
    end
  end

  // Stage p0 -> p1: compare the counter and duty values that take effect
  // this edge, so the pin lines up with periodStart on a new period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_p1 <= 1'b0;
    end else begin
      pwm_p1 <= enable && (period_nxt < active_nxt);
    end
  end

  assign pwm = pwm_p1;

endmodule : mod_pwm_channel

// File: rtl/mod_pwm_pair.sv
// Two-channel servo PWM generator fed by the 16-bit demux. A shared
// prescaler and period counter keep both channels phase-aligned; each
// channel double-buffers its duty so pulses never change mid-period.
// Optional feature: define PWM_CLAMP_EN to clamp loaded duties to the
// servo window (handled inside mod_pwm_channel).
module mod_pwm_pair
  import mod_pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int PERIOD   = PERIOD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] inPort1,
  input  logic [DUTY_W-1:0] inPort2,
  input  logic              sel,
  input  logic              load,
  input  logic              enable,
  output logic              pwmOut1,
  output logic              pwmOut2,
  output logic              periodStart,
  output logic [1:0]        pending
);

  localparam logic [DUTY_W-1:0] PRESC_MAX  = DUTY_W'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] PERIOD_MAX = DUTY_W'(PERIOD - 1);

  logic [DUTY_W-1:0] presc_cnt;
  logic [DUTY_W-1:0] presc_nxt;
  logic [DUTY_W-1:0] period_cnt;
  logic [DUTY_W-1:0] period_nxt;
  logic              tick;
  logic              boundary;
  logic              cap1;
  logic              cap2;
  logic              pend1;
  logic              pend2;
  logic [DUTY_W-1:0] active1;
  logic [DUTY_W-1:0] active2;

  // Tick and boundary decode from the current counter values.
  always_comb begin
    tick     = enable && (presc_cnt == PRESC_MAX);
    boundary = tick && (period_cnt == PERIOD_MAX);
  end

  // Next counter values; disabled counters are parked at 0 so the first
  // enabled period starts from count 0.
  always_comb begin
    presc_nxt  = presc_cnt;
    period_nxt = period_cnt;
    if (!enable) begin
      presc_nxt  = '0;
      period_nxt = '0;
    end else if (tick) begin
      presc_nxt  = '0;
      period_nxt = boundary ? '0 : period_cnt + DUTY_W'(1);
    end else begin
      presc_nxt  = presc_cnt + DUTY_W'(1);
    end
  end

  // Shared prescaler and period counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_cnt  <= '0;
      period_cnt <= '0;
    end else begin
      presc_cnt  <= presc_nxt;
      period_cnt <= period_nxt;
    end
  end

  // One-cycle period-start flag for the cycle after the boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      periodStart <= 1'b0;
    end else begin
      periodStart <= boundary;
    end
  end

  // Route the load strobe to the channel the demux is currently driving.
  always_comb begin
    cap1 = load && (sel == 1'(CH1));
    cap2 = load && (sel == 1'(CH2));
  end

  mod_pwm_channel #(
    .DATA_W (DUTY_W)
  ) u_ch1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .boundary   (boundary),
    .cap        (cap1),
    .din        (inPort1),
    .period_nxt (period_nxt),
    .pwm        (pwmOut1),
    .pending    (pend1),
    .active     (active1)
  );

  mod_pwm_channel #(
    .DATA_W (DUTY_W)
  ) u_ch2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .boundary   (boundary),
    .cap        (cap2),
    .din        (inPort2),
    .period_nxt (period_nxt),
    .pwm        (pwmOut2),
    .pending    (pend2),
    .active     (active2)
  );

  assign pending = {pend2, pend1};

  // Active duties are observed inside the channels; keep the taps tidy.
  logic unused_active;
  assign unused_active = ^{active1, active2};

endmodule : mod_pwm_pair
